dice_roll_scheduler: RTL and testbench
======================================

# dice_roll_scheduler

Shares one `dice_roller` instance among four requesters. Each requester asks for a number of dice of a chosen type. The scheduler grants requesters round-robin, sequences the roller's roll pulses, accumulates the individual results into a sum, and returns that sum with a one-cycle acknowledge. It sits between the game-logic requesters and the roller's `roll` / `die_select` / `rolled_number` ports.

## Interface
- (no parameters) — the design is fixed at 4 requesters, a 3-bit dice count and an 8-bit sum.
- `clk` in 1 — single clock; the roller uses the same clock.
- `rst` in 1 — synchronous, active-high reset.
- `req` in 4 — level request, one bit per requester; held until that requester's `ack`.
- `die_sel_in` in 8 — requester i die type at bits [2i+1:2i]; 00=d4, 01=d6, 10=d8, 11=d20.
- `count_in` in 12 — requester i dice count at bits [3i+2:3i]; value 0 is treated as 1.
- `ack` out 4 — one-hot, one-cycle pulse; marks completion for the granted requester.
- `result_valid` out 1 — high in the same cycle as `ack`.
- `result_id` out 2 — index of the completed requester; valid while `result_valid` is high.
- `result_sum` out 8 — sum of all dice for the request; valid while `result_valid` is high.
- `result_err` out 1 — set if any sampled die value was 0 or greater than the die's side count.
- `busy` out 1 — high in every state except IDLE.
- `roll_o` out 1 — to roller `roll`.
- `die_sel_o` out 2 — to roller `die_select`.
- `rolled_number_i` in 8 — from roller `rolled_number`.

## Operation
- FSM has four states: IDLE, ROLL, CAPT, DONE.
- **IDLE**
  - If any `req` bit is set, grant the first set bit searching from `ptr`, `ptr+1`, … mod 4.
  - On grant, latch `id`, `die_sel` and `remaining` (count, with 0 mapped to 1); clear `acc` and `err`; go to ROLL.
- **ROLL**
  - `roll_o`=1 and `die_sel_o`=latched `die_sel`; go to CAPT.
- **CAPT**
  - `roll_o`=0.
  - Sample `rolled_number_i`: `acc <= acc + rolled_number_i`; `err` is ORed with (value==0 or value>N), where N ∈ {4,6,8,20}.
  - Decrement `remaining`. If it reaches 0, go to DONE; otherwise go to ROLL.
- **DONE**
  - `result_valid`=1, `ack[id]`=1, `result_id`=`id`, `result_sum`=`acc`, `result_err`=`err`.
  - `ptr <= id+1` (mod 4); go to IDLE.
- ROLL/CAPT alternation guarantees `roll_o` is low for at least one cycle between pulses, so the roller's rising-edge detector fires once per die.
- `die_sel_o` holds the latched value from grant until the next grant; it is 00 after reset.
- Sum arithmetic is 8-bit unsigned. The maximum is 7×20=140, so the sum cannot overflow.
- Changes to `req`, `die_sel_in` or `count_in` for the granted requester after grant are ignored until DONE.
- Non-granted requests wait. Deasserting a request before it is granted withdraws it with no side effect.

## Timing
- **Reset values:** state=IDLE, `ptr`=0, `roll_o`=0, `die_sel_o`=00, `ack`=0, `result_valid`=0, `result_id`=0, `result_sum`=0, `result_err`=0, `busy`=0.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- **Roller timing:**
  - The roller loads `rolled_number` at the clock edge that ends the ROLL cycle.
  - CAPT samples it at the following edge.
- **Latency:** with grant at edge E0 and n dice, `ack` is high during the cycle after edge E(2n). Total occupancy is 2n+2 cycles from grant to return to IDLE.
- **End of request:** the requester must drop `req` at the edge that ends its `ack` cycle. Requests are first re-sampled in the IDLE cycle that follows.
- **Back-to-back grants:** the minimum gap between consecutive grants is one IDLE cycle.
- **Reset mid-operation:**
  - Any partial sum is discarded.
  - `roll_o` goes to 0 at the reset edge.
  - No `ack` is issued for the aborted request.
  - The roller is not reset by this block.

## Test plan
- **Single d6, count 1:** `req`[0]=1, `die_sel`=01, `count`=1.
  - `roll_o` is high for exactly one cycle.
  - `ack`=0001 appears 3 cycles after the grant edge.
  - `result_sum` equals the roller output, in the range 1..6, and `result_err`=0.
- **Count 0 and count 7:**
  - `count`=0 produces exactly 1 roll pulse.
  - d20 with `count`=7 produces 7 pulses, each separated by a low cycle.
  - `result_sum` equals the scoreboard sum of the sampled values (≤140).
- **Round-robin:** `req`=1111, each requester held until its ack.
  - Acks occur in order 0,1,2,3.
  - Re-raising `req`[0] with `req`[3] pending still serves 3 before 0.
- **Error flag:** force `rolled_number_i`=0 on one of three d8 rolls.
  - `result_err`=1 and `result_sum` excludes nothing (0 is added).
  - The next request reports `result_err`=0.
- **Reset mid-request:** assert `rst` during CAPT of die 2 of 4.
  - Next cycle: IDLE, `busy`=0, `roll_o`=0, no `ack`.
  - With `req` still high after reset, the request restarts with the full count of 4.
- **Withdrawn request:** `req`[2] pulses high for 1 cycle while requester 1 is busy.
  - No grant and no `ack`[2] are ever issued.

Source files
------------

// File: rtl/dice_roll_scheduler.sv
// Round-robin scheduler sharing one dice roller among four requesters: grants a
// requester, pulses the roller once per die, sums the results and acknowledges.
module dice_roll_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [7:0]  die_sel_in,
  input  logic [11:0] count_in,
  output logic [3:0]  ack,
  output logic        result_valid,
  output logic [1:0]  result_id,
  output logic [7:0]  result_sum,
  output logic        result_err,
  output logic        busy,
  output logic        roll_o,
  output logic [1:0]  die_sel_o,
  input  logic [7:0]  rolled_number_i
);

  typedef enum logic [1:0] {IDLE, ROLL, CAPT, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  ptr;
  logic [1:0]  id;
  logic [1:0]  die_sel_q;
  logic [2:0]  remaining;
  logic [7:0]  acc;
  logic        err;

  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [2:0]  grant_count;
  logic        sample_err;

  function automatic logic [7:0] die_sides(input logic [1:0] sel);
    case (sel)
      2'b00:   return 8'd4;
      2'b01:   return 8'd6;
      2'b10:   return 8'd8;
      default: return 8'd20;
    endcase
  endfunction

  // Walk offsets from the far end so the set bit closest to ptr wins last.
  // NOTE: every variable written in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        grant_valid = 1'b1;
        grant_id    = ptr + 2'(k);
      end
    end
  end

  always_comb begin
    grant_count = count_in[3*grant_id +: 3];
    if (grant_count == 3'd0) grant_count = 3'd1;
  end

  assign sample_err = (rolled_number_i == 8'd0) ||
                      (rolled_number_i > die_sides(die_sel_q));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      id        <= 2'd0;
      die_sel_q <= 2'b00;
      remaining <= 3'd0;
      acc       <= 8'd0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (grant_valid) begin
          id        <= grant_id;
          die_sel_q <= die_sel_in[{grant_id, 1'b0} +: 2];
          remaining <= grant_count;
          acc       <= 8'd0;
          err       <= 1'b0;
        end
        CAPT: begin
          acc       <= acc + rolled_number_i;
          err       <= err | sample_err;
          remaining <= remaining - 3'd1;
        end
        DONE:    ptr <= id + 2'd1;
        default: ;
      endcase
    end
  end

  // Outputs decode only the state and internal registers, never the inputs.
  always_comb begin
    state_next   = state;
    roll_o       = 1'b0;
    busy         = (state != IDLE);
    result_valid = 1'b0;
    ack          = 4'b0000;
    result_id    = 2'd0;
    result_sum   = 8'd0;
    result_err   = 1'b0;
    case (state)
      IDLE: if (grant_valid) state_next = ROLL;
      ROLL: begin
        roll_o     = 1'b1;
        state_next = CAPT;
      end
      CAPT: state_next = (remaining == 3'd1) ? DONE : ROLL;
      DONE: begin
        result_valid = 1'b1;
        ack          = 4'b0001 << id;
        result_id    = id;
        result_sum   = acc;
        result_err   = err;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign die_sel_o = die_sel_q;

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Directed bench for dice_roll_scheduler: a vector table of single requests
// plus hand-written round-robin, mid-request reset and withdrawn-request cases.
module tb_dice_roll_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  die_sel_in;
  logic [11:0] count_in;
  logic [3:0]  ack;
  logic        result_valid;
  logic [1:0]  result_id;
  logic [7:0]  result_sum;
  logic        result_err;
  logic        busy;
  logic        roll_o;
  logic [1:0]  die_sel_o;
  logic [7:0]  rolled_number_i = 8'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dice_roll_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .die_sel_in(die_sel_in), .count_in(count_in),
    .ack(ack), .result_valid(result_valid), .result_id(result_id),
    .result_sum(result_sum), .result_err(result_err), .busy(busy),
    .roll_o(roll_o), .die_sel_o(die_sel_o), .rolled_number_i(rolled_number_i)
  );

  // Roller model: loads the next scripted value on every edge where roll is high.
  logic [7:0] vals [7];
  logic       roll_clr = 1'b0;
  logic       roll_prev = 1'b0;
  int         roll_idx = 0;
  int         pulses = 0;
  int         overlap = 0;

  always @(posedge clk) begin
    if (roll_clr) begin
      roll_idx <= 0;
      pulses   <= 0;
    end else if (roll_o) begin
      rolled_number_i <= vals[roll_idx];
      roll_idx        <= (roll_idx + 1) % 7;
      pulses          <= pulses + 1;
    end
    if (roll_o && roll_prev) overlap <= overlap + 1;
    roll_prev <= roll_o;
  end

  typedef struct {
    logic [1:0] id;
    logic [1:0] die;
    logic [2:0] cnt;
    logic [7:0] vals [7];
    int         exp_pulses;
    logic [7:0] exp_sum;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the roller counters cleared.
  task automatic clear_roller();
    roll_clr = 1'b1;
    @(negedge clk);
    roll_clr = 1'b0;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack == 4'b0000 && lat < 40);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    vals = v.vals;
    clear_roller();
    die_sel_in = 8'hFF;
    count_in   = 12'hFFF;
    die_sel_in[2*v.id +: 2] = v.die;
    count_in[3*v.id +: 3]   = v.cnt;
    req = 4'b0001 << v.id;
    wait_ack(lat);
    check("vec_latency", lat, 2 * v.exp_pulses + 1);
    check("vec_ack", ack, 4'b0001 << v.id);
    check("vec_valid", result_valid, 1);
    check("vec_id", result_id, v.id);
    check("vec_sum", result_sum, v.exp_sum);
    check("vec_err", result_err, v.exp_err);
    check("vec_pulses", pulses, v.exp_pulses);
    check("vec_die_sel_o", die_sel_o, v.die);
    req = 4'b0000;
    @(negedge clk);
    check("vec_idle_busy", busy, 0);
    check("vec_idle_valid", result_valid, 0);
  endtask

  vec_t vec [8];
  logic [3:0] order [5];
  int lat;
  int n_acks;
  int ack1_cnt;
  int ack2_cnt;

  initial begin
    vec[0] = '{2'd0, 2'b01, 3'd1, '{8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},      1, 8'd4,   1'b0};
    vec[1] = '{2'd1, 2'b00, 3'd0, '{8'd3, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9},      1, 8'd3,   1'b0};
    vec[2] = '{2'd2, 2'b11, 3'd7, '{8'd20, 8'd19, 8'd1, 8'd7, 8'd13, 8'd20, 8'd20}, 7, 8'd100, 1'b0};
    vec[3] = '{2'd3, 2'b10, 3'd3, '{8'd5, 8'd0, 8'd8, 8'd1, 8'd1, 8'd1, 8'd1},      3, 8'd13,  1'b1};
    vec[4] = '{2'd3, 2'b10, 3'd2, '{8'd8, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1},      2, 8'd10,  1'b0};
    vec[5] = '{2'd0, 2'b00, 3'd2, '{8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1},      2, 8'd6,   1'b1};
    vec[6] = '{2'd1, 2'b01, 3'd3, '{8'd6, 8'd6, 8'd7, 8'd1, 8'd1, 8'd1, 8'd1},      3, 8'd19,  1'b1};
    vec[7] = '{2'd2, 2'b11, 3'd2, '{8'd21, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1},     2, 8'd21,  1'b1};

    rst = 1'b1;
    req = 4'b0000;
    die_sel_in = 8'h00;
    count_in = 12'h000;
    foreach (vals[i]) vals[i] = 8'd1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_roll", roll_o, 0);
    check("rst_die_sel", die_sel_o, 0);
    check("rst_ack", ack, 0);
    check("rst_valid", result_valid, 0);
    check("rst_id", result_id, 0);
    check("rst_sum", result_sum, 0);
    check("rst_err", result_err, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vec[i]);

    // Round-robin from ptr=0; requester 0 re-raises while 3 is still pending.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    foreach (vals[i]) vals[i] = 8'd1;
    clear_roller();
    die_sel_in = 8'h00;
    count_in   = 12'h000;
    req = 4'b1111;
    n_acks = 0;
    for (int c = 0; c < 200 && n_acks < 5; c++) begin
      @(negedge clk);
      if (ack != 4'b0000) begin
        order[n_acks] = ack;
        n_acks++;
        check("rr_sum", result_sum, 1);
        req = req & ~ack;
        if (ack == 4'b0010) req[0] = 1'b1;
      end
    end
    req = 4'b0000;
    check("rr_n_acks", n_acks, 5);
    check("rr_order0", order[0], 4'b0001);
    check("rr_order1", order[1], 4'b0010);
    check("rr_order2", order[2], 4'b0100);
    check("rr_order3", order[3], 4'b1000);
    check("rr_order4", order[4], 4'b0001);
    @(negedge clk);

    // Reset during CAPT of die 2 of 4; the held request then restarts in full.
    vals = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd1, 8'd1};
    clear_roller();
    die_sel_in = 8'hFF;
    count_in   = 12'hFFF;
    die_sel_in[3:2] = 2'b01;
    count_in[5:3]   = 3'd4;
    req = 4'b0010;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(pulses == 2 && !roll_o && busy) && lat < 20);
    check("mid_reached_capt2", lat, 4);
    rst = 1'b1;
    clear_roller();
    check("mid_busy", busy, 0);
    check("mid_roll", roll_o, 0);
    check("mid_ack", ack, 0);
    rst = 1'b0;
    wait_ack(lat);
    check("mid_latency", lat, 9);
    check("mid_ack_after", ack, 4'b0010);
    check("mid_pulses", pulses, 4);
    check("mid_sum", result_sum, 14);
    check("mid_err", result_err, 0);
    req = 4'b0000;
    @(negedge clk);

    // Requester 2 pulses for one cycle while requester 1 is busy.
    vals = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd1, 8'd1, 8'd1};
    clear_roller();
    die_sel_in = 8'h00;
    count_in   = 12'h000;
    count_in[5:3] = 3'd3;
    req = 4'b0010;
    repeat (2) @(negedge clk);
    req = 4'b0110;
    @(negedge clk);
    req = 4'b0010;
    ack1_cnt = 0;
    ack2_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack[2]) ack2_cnt++;
      if (ack[1]) begin
        ack1_cnt++;
        check("wd_sum", result_sum, 6);
        req = 4'b0000;
      end
    end
    check("wd_ack1_count", ack1_cnt, 1);
    check("wd_ack2_count", ack2_cnt, 0);
    check("wd_final_busy", busy, 0);
    check("roll_gap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
